// File: rtl/uart_rx_deserializer_if.sv
// Parallel result bus of the UART receiver: received byte plus per-frame status pulses.
// The receiver drives the master side; the FIFO/system controller observes the slave side.
interface uart_rx_deserializer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;

  modport master (
    output P_DATA,
    output data_valid,
    output parity_error,
    output stop_error
  );

  modport slave (
    input P_DATA,
    input data_valid,
    input parity_error,
    input stop_error
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive path: oversampled start detection, 3-point majority bit sampling,
// LSB-first deserialization, optional parity and stop checking with one-cycle result pulses.
module uart_rx_deserializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  RST_n,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  uart_rx_deserializer_if.master rx_if
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e state_q, state_d;

  logic                  rx_meta_q, rx_s_q;
  logic [PRESCALE_W-1:0] pres_q, pres_d, pres_sel;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [2:0]            samp_q, samp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [CntW-1:0]       bit_q, bit_d;
  logic                  par_flag_q, par_flag_d;
  logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;

  logic [PRESCALE_W-1:0] half, last;
  logic                  start_det, bit_end, maj, active;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    pres_sel = PRESCALE_W'(8);
    if (Prescale == PRESCALE_W'(16) || Prescale == PRESCALE_W'(32)) begin
      pres_sel = Prescale;
    end
  end

  assign half      = pres_q >> 1;
  assign last      = pres_q - PRESCALE_W'(1);
  assign start_det = (state_q == StIdle) && !rx_s_q;
  assign bit_end   = (edge_q == last);
  assign active    = (state_q == StStart) || (state_q == StData) ||
                     (state_q == StParity) || (state_q == StStop);
  assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                     (samp_q[1] & samp_q[2]);

  // Edge counter, majority samples and frame configuration latch.
  always_comb begin
    pres_d    = pres_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    edge_d    = '0;
    samp_d    = samp_q;
    if (start_det) begin
      pres_d    = pres_sel;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      edge_d    = PRESCALE_W'(1);
    end else if (active) begin
      edge_d = bit_end ? '0 : edge_q + PRESCALE_W'(1);
    end
    if (edge_q == half - PRESCALE_W'(1)) samp_d[0] = rx_s_q;
    if (edge_q == half)                  samp_d[1] = rx_s_q;
    if (edge_q == half + PRESCALE_W'(1)) samp_d[2] = rx_s_q;
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (!rx_s_q) state_d = StStart;
      StStart:  if (bit_end) state_d = maj ? StIdle : StData;
      StData: begin
        if (bit_end && bit_q == CntW'(DATA_WIDTH - 1)) begin
          state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: if (bit_end) state_d = StStop;
      StStop:   if (bit_end) state_d = maj ? StIdle : StBreak;
      StBreak:  if (rx_s_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    bit_d      = bit_q;
    par_flag_d = par_flag_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    case (state_q)
      StIdle: begin
        bit_d      = '0;
        par_flag_d = 1'b0;
      end
      StData: begin
        if (bit_end) begin
          shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
          bit_d   = bit_q + CntW'(1);
        end
      end
      StParity: begin
        if (bit_end && (maj != ((^shift_q) ^ par_typ_q))) par_flag_d = 1'b1;
      end
      StStop: begin
        if (bit_end) begin
          if (maj) begin
            if (par_flag_q) begin
              pe_d = 1'b1;
            end else begin
              dv_d     = 1'b1;
              p_data_d = shift_q;
            end
          end else begin
            se_d = 1'b1;
            pe_d = par_flag_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      pres_q     <= PRESCALE_W'(8);
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      edge_q     <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      par_flag_q <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      pres_q     <= pres_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      edge_q     <= edge_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      par_flag_q <= par_flag_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign rx_if.P_DATA       = p_data_q;
  assign rx_if.data_valid   = dv_q;
  assign rx_if.parity_error = pe_q;
  assign rx_if.stop_error   = se_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: frame-level stimulus feeds a queue of
// expected outcomes; an independent monitor compares every result pulse against it.
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       RST_n;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_last = 8'h00;

  uart_rx_deserializer_if #(.DATA_WIDTH(8)) rx_if ();

  uart_rx_deserializer #(
    .DATA_WIDTH(8),
    .PRESCALE_W(6)
  ) dut (
    .clk     (clk),
    .RST_n   (RST_n),
    .RX_IN   (RX_IN),
    .Prescale(Prescale),
    .PAR_EN  (PAR_EN),
    .PAR_TYP (PAR_TYP),
    .rx_if   (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int eff_p(input logic [5:0] p);
    if (p == 6'd16 || p == 6'd32) return int'(p);
    return 8;
  endfunction

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns exactly N*P cycles later with the line left at stop_bit.
  task automatic send_frame(input logic [7:0] d, input logic [5:0] pres, input logic pen,
                            input logic ptyp, input bit bad_par, input logic stop_bit,
                            input bit scramble);
    int   p = eff_p(pres);
    int   n = pen ? 11 : 10;
    bit   par_ok = !(pen && bad_par);
    exp_t e;
    Prescale = pres;
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    e.dv  = stop_bit && par_ok;
    e.pe  = !par_ok;
    e.se  = !stop_bit;
    if (e.dv) model_last = d;
    e.data = model_last;
    e.cyc  = cyc + 2 + n * p;
    exp_q.push_back(e);
    RX_IN = 1'b0;
    repeat (p) @(negedge clk);
    if (scramble) begin
      Prescale = 6'($urandom);
      PAR_EN   = 1'($urandom);
      PAR_TYP  = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (p) @(negedge clk);
    end
    if (pen) begin
      RX_IN = (^d) ^ ptyp ^ bad_par;
      repeat (p) @(negedge clk);
    end
    RX_IN = stop_bit;
    repeat (p) @(negedge clk);
  endtask

  task automatic glitch(input int g, input logic [5:0] pres);
    Prescale = pres;
    RX_IN = 1'b0;
    repeat (g) @(negedge clk);
    idle(40);
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_if.data_valid || rx_if.parity_error || rx_if.stop_error) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {29'd0, rx_if.data_valid, rx_if.parity_error,
                                   rx_if.stop_error}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("data_valid", {31'd0, rx_if.data_valid}, {31'd0, e.dv});
          chk("parity_error", {31'd0, rx_if.parity_error}, {31'd0, e.pe});
          chk("stop_error", {31'd0, rx_if.stop_error}, {31'd0, e.se});
          chk("P_DATA", {24'd0, rx_if.P_DATA}, {24'd0, e.data});
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        e = exp_q.pop_front();
        chk("missed_pulse_at", cyc, e.cyc);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pres_tab[3];
    int         kind;
    logic [5:0] pres;
    logic       pen, stop_b;
    bit         bad;
    pres_tab[0] = 6'd8;
    pres_tab[1] = 6'd16;
    pres_tab[2] = 6'd32;

    RST_n = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_P_DATA", {24'd0, rx_if.P_DATA}, 32'd0);
    chk("rst_data_valid", {31'd0, rx_if.data_valid}, 32'd0);
    chk("rst_parity_error", {31'd0, rx_if.parity_error}, 32'd0);
    chk("rst_stop_error", {31'd0, rx_if.stop_error}, 32'd0);
    RST_n = 1'b1;
    idle(5);

    send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    send_frame(8'h3C, 6'd16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(5);
    glitch(2, 6'd8);
    send_frame(8'h5A, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    // Stop bit low followed by a held-low line must not retrigger.
    send_frame(8'h81, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    RX_IN = 1'b0;
    repeat (40) @(negedge clk);
    idle(10);
    send_frame(8'h42, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    send_frame(8'h11, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h33, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);

    // Reset during bit 4 of a 0xFF frame.
    Prescale = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (8) @(negedge clk);
    RX_IN = 1'b1;
    repeat (8 * 4 + 2) @(negedge clk);
    chk("pending_before_reset", exp_q.size(), 32'd0);
    RST_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_P_DATA", {24'd0, rx_if.P_DATA}, 32'd0);
    chk("midrst_data_valid", {31'd0, rx_if.data_valid}, 32'd0);
    chk("midrst_parity_error", {31'd0, rx_if.parity_error}, 32'd0);
    chk("midrst_stop_error", {31'd0, rx_if.stop_error}, 32'd0);
    RST_n = 1'b1;
    model_last = 8'h00;
    idle(5);
    send_frame(8'h0F, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    for (int k = 0; k < 30; k++) begin
      kind = $urandom_range(0, 9);
      pres = ($urandom_range(0, 4) == 0) ? 6'($urandom) : pres_tab[$urandom_range(0, 2)];
      if (kind == 0) begin
        glitch($urandom_range(1, 3), pres);
      end else begin
        pen    = 1'($urandom);
        bad    = pen && (kind == 1 || kind == 3);
        stop_b = !(kind == 2 || kind == 3);
        send_frame(8'($urandom), pres, pen, 1'($urandom), bad, stop_b, 1'($urandom));
        if (!stop_b) idle($urandom_range(4, 8));
        else idle($urandom_range(0, 3));
      end
    end

    idle(40);
    chk("pending_at_end", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
